regfile_fp_sb: RTL and testbench



---
 rtl/fp_rf_pkg.sv | 40 ++++
 rtl/regfile_fp_sb_scoreboard.sv | 47 ++++
 rtl/regfile_fp_sb.sv | 125 ++++++++++++
 tb/tb_regfile_fp_sb.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rf_pkg.sv
// Shared types, defaults and write-port arbitration for the FP register file.
// Pure declarations and one combinational helper; no state, no backpressure.
package fp_rf_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    localparam int FP_RF_DATA_W = 16;
    localparam int FP_RF_NREGS  = 32;

    // Helper works on ports/addresses zero-extended to these maxima.
    localparam int FP_RF_MAX_WR = 8;
    localparam int FP_RF_MAX_AW = 8;
    localparam int FP_RF_WIDX_W = 3;

    typedef struct packed {
        logic                    hit;
        logic [FP_RF_WIDX_W-1:0] idx;
    } wsel_t;

    // Highest-numbered enabled port matching addr wins.
    function automatic wsel_t fp_rf_wsel(
        input logic [FP_RF_MAX_WR-1:0]              we,
        input logic [FP_RF_MAX_WR*FP_RF_MAX_AW-1:0] waddr,
        input logic [FP_RF_MAX_AW-1:0]              addr
    );
        wsel_t s;
        s = '0;
        for (int j = 0; j < FP_RF_MAX_WR; j++) begin
            if (we[j] && (waddr[j*FP_RF_MAX_AW +: FP_RF_MAX_AW] == addr)) begin
                s.hit = 1'b1;
                s.idx = j[FP_RF_WIDX_W-1:0];
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/regfile_fp_sb_scoreboard.sv
// Pending-write scoreboard: busy set the cycle after a reservation, cleared the cycle after a write.
// resv_ready is combinational; a refused reservation is dropped and issue must retry.
module fp_rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 4,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NRD-1:0]    rd_hit,
    input  logic [NREGS-1:0]  wr_hit,
    input  logic              resv_valid,
    input  logic [AW-1:0]     resv_addr,
    input  logic              clr_busy,
    input  logic [AW-1:0]     clr_idx,
    output logic [NRD-1:0]    rbusy,
    output logic              resv_ready
);

    logic [NREGS-1:0] busy;
    logic             resv_acc;

    assign resv_ready = !busy[resv_addr] && !clr_busy;
    assign resv_acc   = resv_valid && resv_ready;

    for (genvar r = 0; r < NREGS; r++) begin : g_busy
        logic q;
        // Reservation outranks a same-cycle write so the newer producer stays tracked.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= 1'b0;
            else if (clr_busy && (clr_idx == AW'(r)))
                q <= 1'b0;
            else if (resv_acc && (resv_addr == AW'(r)))
                q <= 1'b1;
            else if (wr_hit[r])
                q <= 1'b0;
        end
        assign busy[r] = q;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        assign rbusy[k] = busy[raddr[k*AW +: AW]] && !rd_hit[k];
    end

endmodule

// File: rtl/regfile_fp_sb.sv
// Multi-port FP register file with optional write-to-read bypass, scoreboard and clear engine.
// Zero-latency reads, writes land next edge; during a clear writes and reservations are ignored.
module regfile_fp_sb
    import fp_rf_pkg::*;
#(
    parameter int DATA_W = FP_RF_DATA_W,
    parameter int NREGS  = FP_RF_NREGS,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     waddr,
    input  logic [NWR*DATA_W-1:0] wdata,
    input  logic                  resv_valid,
    input  logic [AW-1:0]         resv_addr,
    output logic                  resv_ready,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    clr_state_t       state, state_nxt;
    logic [AW-1:0]    clr_idx;
    logic             clr_run;
    logic [NWR-1:0]   we_eff;
    logic [FP_RF_MAX_WR-1:0]              we_x;
    logic [FP_RF_MAX_WR*FP_RF_MAX_AW-1:0] waddr_x;
    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  wr_hit;
    logic [NRD-1:0]    rd_hit;

    assign clr_run  = (state == CLR_RUN);
    assign clr_busy = clr_run;
    assign we_eff   = clr_run ? '0 : we;

    always_comb begin
        we_x    = '0;
        waddr_x = '0;
        for (int j = 0; j < NWR; j++) begin
            we_x[j] = we_eff[j];
            waddr_x[j*FP_RF_MAX_AW +: FP_RF_MAX_AW] = FP_RF_MAX_AW'(waddr[j*AW +: AW]);
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_reg
        wsel_t             ws;
        logic [DATA_W-1:0] q;
        assign ws = fp_rf_wsel(we_x, waddr_x, FP_RF_MAX_AW'(r));
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                q <= '0;
            else if (clr_run && (clr_idx == AW'(r)))
                q <= '0;
            else if (ws.hit)
                q <= wdata[ws.idx*DATA_W +: DATA_W];
        end
        assign mem[r]    = q;
        assign wr_hit[r] = ws.hit;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        wsel_t rs;
        assign rs        = fp_rf_wsel(we_x, waddr_x, FP_RF_MAX_AW'(raddr[k*AW +: AW]));
        assign rd_hit[k] = (BYPASS != 0) && rs.hit;
        assign rdata[k*DATA_W +: DATA_W] = rd_hit[k] ? wdata[rs.idx*DATA_W +: DATA_W]
                                                      : mem[raddr[k*AW +: AW]];
    end

    fp_rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (raddr),
        .rd_hit     (rd_hit),
        .wr_hit     (wr_hit),
        .resv_valid (resv_valid),
        .resv_addr  (resv_addr),
        .clr_busy   (clr_busy),
        .clr_idx    (clr_idx),
        .rbusy      (rbusy),
        .resv_ready (resv_ready)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= CLR_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clr_idx <= '0;
        else if (clr_run)
            clr_idx <= clr_idx + 1'b1;
        else if (clr_req)
            clr_idx <= '0;
    end

    always_comb begin
        state_nxt = state;
        clr_done  = 1'b0;
        case (state)
            CLR_IDLE: if (clr_req) state_nxt = CLR_RUN;
            CLR_RUN: begin
                if (clr_idx == AW'(NREGS-1)) begin
                    clr_done  = 1'b1;
                    state_nxt = CLR_IDLE;
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

endmodule

// File: tb/tb_regfile_fp_sb.sv
// Directed bench for regfile_fp_sb (defaults, BYPASS=1) with hand-computed expectations.
module tb_regfile_fp_sb;

    localparam int DW  = 16;
    localparam int NR  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int NWR = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*DW-1:0]   rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*DW-1:0]   wdata;
    logic                resv_valid;
    logic [AW-1:0]       resv_addr;
    logic                resv_ready;
    logic                clr_req;
    logic                clr_busy;
    logic                clr_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_fp_sb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr      (raddr),
        .rdata      (rdata),
        .rbusy      (rbusy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .resv_valid (resv_valid),
        .resv_addr  (resv_addr),
        .resv_ready (resv_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    function automatic logic [DW-1:0] rd(input int k);
        return rdata[k*DW +: DW];
    endfunction

    task automatic set_ra(input int k, input int a);
        raddr[k*AW +: AW] = AW'(a);
    endtask

    task automatic wr_set(input int p, input int a, input logic [DW-1:0] d);
        we[p] = 1'b1;
        waddr[p*AW +: AW] = AW'(a);
        wdata[p*DW +: DW] = d;
    endtask

    int n, done_cnt, done_at;

    initial begin
        rst_n = 1'b0; raddr = '0; we = '0; waddr = '0; wdata = '0;
        resv_valid = 1'b0; resv_addr = '0; clr_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle;

        // 1: reset state
        chk("rst_resv_ready", 32'(resv_ready), 32'd1);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_clr_done", 32'(clr_done), 32'd0);
        for (int r = 0; r < NR; r++) begin
            set_ra(0, r);
            settle;
            chk($sformatf("rst_rdata_%0d", r), 32'(rd(0)), 32'd0);
            chk($sformatf("rst_rbusy_%0d", r), 32'(rbusy[0]), 32'd0);
        end

        // 2: two ports to one address, highest port wins; bypass visible same cycle
        wr_set(0, 5, 16'h3C00);
        wr_set(1, 5, 16'h4000);
        set_ra(0, 5);
        settle;
        chk("byp_same_addr", 32'(rd(0)), 32'h4000);
        tick;
        we = '0;
        settle;
        chk("wr_same_addr", 32'(rd(0)), 32'h4000);

        // parallel writes to different addresses
        wr_set(0, 1, 16'h1111);
        wr_set(1, 2, 16'h2222);
        tick;
        we = '0;
        set_ra(1, 1); set_ra(2, 2); set_ra(3, 5);
        settle;
        chk("par_wr_p0", 32'(rd(1)), 32'h1111);
        chk("par_wr_p1", 32'(rd(2)), 32'h2222);
        chk("par_keep5", 32'(rd(3)), 32'h4000);

        // 3: reservation then write clears busy
        resv_valid = 1'b1; resv_addr = 5'd7;
        settle;
        chk("resv7_ready_pre", 32'(resv_ready), 32'd1);
        tick;
        resv_valid = 1'b0;
        set_ra(0, 7);
        settle;
        chk("resv7_rbusy", 32'(rbusy[0]), 32'd1);
        chk("resv7_ready_post", 32'(resv_ready), 32'd0);
        wr_set(0, 7, 16'h1234);
        settle;
        chk("resv7_byp_rbusy", 32'(rbusy[0]), 32'd0);
        chk("resv7_byp_data", 32'(rd(0)), 32'h1234);
        tick;
        we = '0;
        settle;
        chk("resv7_clr_rbusy", 32'(rbusy[0]), 32'd0);
        chk("resv7_data", 32'(rd(0)), 32'h1234);
        chk("resv7_ready_again", 32'(resv_ready), 32'd1);

        // 4: reservation and write to same register in one cycle
        resv_valid = 1'b1; resv_addr = 5'd9;
        wr_set(1, 9, 16'hABCD);
        tick;
        resv_valid = 1'b0; we = '0;
        set_ra(0, 9);
        settle;
        chk("rw9_rbusy", 32'(rbusy[0]), 32'd1);
        chk("rw9_data", 32'(rd(0)), 32'hABCD);

        // 5: fill, then clear sequence
        for (int i = 0; i < NR / 2; i++) begin
            wr_set(0, 2 * i, 16'hFFFF);
            wr_set(1, 2 * i + 1, 16'hFFFF);
            tick;
        end
        we = '0;
        set_ra(0, 3); set_ra(1, 0);
        settle;
        chk("fill_r3", 32'(rd(0)), 32'hFFFF);
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        resv_addr = 5'd12;
        for (int c = 0; c < NR; c++) begin
            settle;
            chk($sformatf("clr_busy_c%0d", c), 32'(clr_busy), 32'd1);
            chk($sformatf("clr_done_c%0d", c), 32'(clr_done), (c == NR - 1) ? 32'd1 : 32'd0);
            if (c == 2) begin
                chk("clr_r3_not_yet", 32'(rd(0)), 32'hFFFF);
                chk("clr_r0_done", 32'(rd(1)), 32'd0);
            end
            if (c == 20) chk("clr_resv_ready", 32'(resv_ready), 32'd0);
            we = '0; clr_req = 1'b0; resv_valid = 1'b0;
            if (c == 5) wr_set(0, 3, 16'h5555);
            if (c == 10) clr_req = 1'b1;
            if (c == 20) resv_valid = 1'b1;
            tick;
        end
        we = '0; clr_req = 1'b0; resv_valid = 1'b0;
        settle;
        chk("clr_end_busy", 32'(clr_busy), 32'd0);
        chk("clr_end_done", 32'(clr_done), 32'd0);
        for (int r = 0; r < NR; r++) begin
            set_ra(0, r);
            settle;
            chk($sformatf("clr_rdata_%0d", r), 32'(rd(0)), 32'd0);
            chk($sformatf("clr_rbusy_%0d", r), 32'(rbusy[0]), 32'd0);
        end

        // 6: reset in the middle of a clear
        wr_set(0, 20, 16'h7777);
        resv_valid = 1'b1; resv_addr = 5'd25;
        tick;
        we = '0; resv_valid = 1'b0;
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        repeat (10) tick;
        set_ra(0, 20); set_ra(1, 25);
        settle;
        chk("mid_r20_live", 32'(rd(0)), 32'h7777);
        chk("mid_r25_busy", 32'(rbusy[1]), 32'd1);
        chk("mid_clr_busy", 32'(clr_busy), 32'd1);
        rst_n = 1'b0;
        settle;
        chk("arst_clr_busy", 32'(clr_busy), 32'd0);
        chk("arst_clr_done", 32'(clr_done), 32'd0);
        chk("arst_r20", 32'(rd(0)), 32'd0);
        chk("arst_r25_busy", 32'(rbusy[1]), 32'd0);
        #3 rst_n = 1'b1;
        tick;
        clr_req = 1'b1;
        tick;
        clr_req = 1'b0;
        n = 0; done_cnt = 0; done_at = -1;
        while (clr_busy && n < 100) begin
            if (clr_done) begin
                done_cnt++;
                done_at = n;
            end
            n++;
            tick;
        end
        chk("rerun_len", 32'(n), 32'd32);
        chk("rerun_done_cnt", 32'(done_cnt), 32'd1);
        chk("rerun_done_at", 32'(done_at), 32'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
